// File: rtl/husky_pkg.sv
// Shared constants and types for the HuskyLens command-frame transmitter.
package husky_pkg;

    localparam logic [7:0] HUSKY_HDR0    = 8'h55;
    localparam logic [7:0] HUSKY_HDR1    = 8'hAA;
    localparam logic [7:0] HUSKY_ADDR    = 8'h11;

    localparam logic [7:0] HUSKY_KNOCK   = 8'h2C;
    localparam logic [7:0] HUSKY_REQUEST = 8'h20;
    localparam logic [7:0] HUSKY_ALGO    = 8'h2D;

    // Header, address, length, command and checksum bytes around the payload
    localparam int HUSKY_OVH = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } husky_state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: LSB first, one start and one stop bit, line idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_e;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    assign tx_ready = (state_q == U_IDLE);
    assign tx       = tx_q;

    // Bit sequencer; tx_data is captured at the end of the start bit so the
    // producer may register it in the same cycle it pulses tx_start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            U_IDLE: begin
                if (tx_start) begin
                    state_d = U_START;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            U_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = U_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    shift_d = tx_data;
                    tx_d    = tx_data[0];
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = U_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = U_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/husky_packet_tx.sv
// HuskyLens command-frame transmitter: 55 AA ADDR LEN CMD DATA[] CSUM over uart_tx.
module husky_packet_tx
    import husky_pkg::*;
#(
    parameter int         MAX_DATA     = 16,
    parameter logic [7:0] ADDR         = HUSKY_ADDR,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_start,
    input  logic [7:0]            req_cmd,
    input  logic [7:0]            req_len,
    input  logic [8*MAX_DATA-1:0] req_data,
    output logic                  req_busy,
    output logic                  req_done,
    output logic                  req_err,
    output logic                  tx
);

    localparam int IDX_W = $clog2(MAX_DATA + HUSKY_OVH);

    husky_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [8*MAX_DATA-1:0] data_q, data_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  err_q, err_d;

    logic [7:0] idx_ext_s;
    logic [7:0] csum_slot_s;
    logic [7:0] data_byte_s;
    logic [7:0] frame_byte_s;
    logic       tx_start_s;
    logic       tx_ready_s;

    assign req_busy = (state_q != ST_IDLE);
    assign req_err  = err_q;

    // Frame byte selected by idx; the last slot carries the running checksum
    always_comb begin
        idx_ext_s   = 8'(idx_q);
        csum_slot_s = len_q + 8'(HUSKY_OVH - 1);
        data_byte_s = 8'd0;
        for (int k = 0; k < MAX_DATA; k++) begin
            data_byte_s |= (idx_ext_s == 8'(k + 5)) ? data_q[8*k +: 8] : 8'd0;
        end
        case (idx_ext_s)
            8'd0:    frame_byte_s = HUSKY_HDR0;
            8'd1:    frame_byte_s = HUSKY_HDR1;
            8'd2:    frame_byte_s = ADDR;
            8'd3:    frame_byte_s = len_q;
            8'd4:    frame_byte_s = cmd_q;
            default: frame_byte_s = (idx_ext_s < csum_slot_s) ? data_byte_s : csum_q;
        endcase
    end

    // Request FSM: accept/reject, then one LOAD/SEND/WAIT pass per frame byte
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        len_d      = len_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        err_d      = 1'b0;
        tx_start_s = 1'b0;
        req_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_start) begin
                    if (req_len <= 8'(MAX_DATA)) begin
                        len_d   = req_len;
                        cmd_d   = req_cmd;
                        data_d  = req_data;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_data_d  = frame_byte_s;
                tx_start_s = 1'b1;
                if (idx_ext_s != csum_slot_s) begin
                    csum_d = csum_add(csum_q, frame_byte_s);
                end else begin
                    csum_d = csum_q;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_ready_s) begin
                    if (idx_ext_s == csum_slot_s) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                req_done = 1'b1;
                idx_d    = '0;
                csum_d   = 8'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            csum_q    <= 8'd0;
            len_q     <= 8'd0;
            cmd_q     <= 8'd0;
            data_q    <= '0;
            tx_data_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start_s),
        .tx_data  (tx_data_q),
        .tx_ready (tx_ready_s),
        .tx       (tx)
    );

endmodule

// File: tb/tb_husky_packet_tx.sv
// Bench for husky_packet_tx: decodes the UART line and compares it with frames built from the protocol rules.
module tb_husky_packet_tx;
    import husky_pkg::*;

    localparam int MD     = 16;
    localparam int CPB    = 4;
    localparam int BUDGET = 4000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_start = 1'b0;
    logic [7:0]      req_cmd = 8'd0;
    logic [7:0]      req_len = 8'd0;
    logic [8*MD-1:0] req_data = '0;
    logic            req_busy, req_done, req_err, tx;

    int         total = 0;
    int         bad = 0;
    int         stop_errs = 0;
    logic       rx_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    husky_packet_tx #(
        .MAX_DATA     (MD),
        .ADDR         (HUSKY_ADDR),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_start (req_start),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_busy  (req_busy),
        .req_done  (req_done),
        .req_err   (req_err),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // UART receiver: samples each bit in its middle
    always begin : uart_rx
        logic [7:0] b;
        @(posedge clk);
        #1;
        if (rx_en && tx == 1'b0) begin
            repeat (CPB/2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                b[i] = tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            if (tx !== 1'b1) stop_errs++;
            rx_q.push_back(b);
        end
    end

    function automatic void build_frame(input logic [7:0] cmd, input logic [7:0] len,
                                        input logic [8*MD-1:0] data);
        int sum;
        exp_q.delete();
        exp_q.push_back(HUSKY_HDR0);
        exp_q.push_back(HUSKY_HDR1);
        exp_q.push_back(HUSKY_ADDR);
        exp_q.push_back(len);
        exp_q.push_back(cmd);
        for (int k = 0; k < int'(len); k++) exp_q.push_back(data[8*k +: 8]);
        sum = 0;
        foreach (exp_q[i]) sum += int'(exp_q[i]);
        exp_q.push_back(8'(sum % 256));
    endfunction

    task automatic issue(input logic [7:0] cmd, input logic [7:0] len, input logic [8*MD-1:0] data);
        @(posedge clk);
        #1;
        req_cmd   = cmd;
        req_len   = len;
        req_data  = data;
        req_start = 1'b1;
        @(posedge clk);
        #1;
        req_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (req_done !== 1'b1 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s_done_seen", tag), 32'(req_done), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        chk($sformatf("%s_nbytes", tag), 32'(rx_q.size()), 32'(exp_q.size()));
        chk($sformatf("%s_stop", tag), 32'(stop_errs), 32'd0);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input logic [8*MD-1:0] data);
        build_frame(cmd, len, data);
        rx_q.delete();
        stop_errs = 0;
        issue(cmd, len, data);
        chk($sformatf("%s_busy_rise", tag), 32'(req_busy), 32'd1);
        chk($sformatf("%s_no_err", tag), 32'(req_err), 32'd0);
        wait_done(tag);
        @(posedge clk);
        #1;
        chk($sformatf("%s_done_once", tag), 32'(req_done), 32'd0);
        chk($sformatf("%s_busy_fall", tag), 32'(req_busy), 32'd0);
        check_frame(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*MD-1:0] d;
        logic [8*MD-1:0] d2;
        logic [7:0]      rl;
        int              hits;
        int              n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(req_busy), 32'd0);
        chk("rst_done", 32'(req_done), 32'd0);
        chk("rst_err",  32'(req_err),  32'd0);
        chk("rst_tx",   32'(tx),       32'd1);
        rst   = 1'b0;
        rx_en = 1'b1;

        run_frame("knock", HUSKY_KNOCK, 8'd0, '0);

        d = '0;
        d[15:0] = 16'h0100;
        run_frame("payload", HUSKY_ALGO, 8'd2, d);

        d = '1;
        run_frame("maxlen", 8'h00, 8'd16, d);

        for (int r = 0; r < 2; r++) begin
            rl = (r == 0) ? 8'd17 : 8'($urandom_range(17, 255));
            @(posedge clk);
            #1;
            req_cmd   = HUSKY_REQUEST;
            req_len   = rl;
            req_start = 1'b1;
            @(posedge clk);
            #1;
            req_start = 1'b0;
            chk($sformatf("rej%0d_err", r),  32'(req_err),  32'd1);
            chk($sformatf("rej%0d_busy", r), 32'(req_busy), 32'd0);
            hits = 0;
            for (int i = 0; i < 2*CPB; i++) begin
                @(posedge clk);
                #1;
                if (tx !== 1'b1 || req_busy !== 1'b0 || req_err !== 1'b0) hits++;
            end
            chk($sformatf("rej%0d_quiet", r), 32'(hits), 32'd0);
        end

        // Request arriving mid-frame is ignored, then taken once the frame completes
        for (int k = 0; k < MD; k++) begin
            d[8*k +: 8]  = 8'($urandom);
            d2[8*k +: 8] = 8'($urandom);
        end
        build_frame(HUSKY_REQUEST, 8'd3, d);
        rx_q.delete();
        stop_errs = 0;
        issue(HUSKY_REQUEST, 8'd3, d);
        repeat (60) @(posedge clk);
        #1;
        chk("hold_busy_mid", 32'(req_busy), 32'd1);
        req_cmd   = HUSKY_KNOCK;
        req_len   = 8'd1;
        req_data  = d2;
        req_start = 1'b1;
        wait_done("hold_a");
        @(posedge clk);
        #1;
        chk("hold_idle_gap", 32'(req_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("hold_b_accept", 32'(req_busy), 32'd1);
        req_start = 1'b0;
        check_frame("hold_a");
        build_frame(HUSKY_KNOCK, 8'd1, d2);
        rx_q.delete();
        wait_done("hold_b");
        @(posedge clk);
        #1;
        check_frame("hold_b");

        // Reset in the middle of the fourth byte
        rx_q.delete();
        issue(HUSKY_ALGO, 8'd4, d);
        n = 0;
        while (rx_q.size() < 3 && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reach", 32'(rx_q.size() >= 3), 32'd1);
        repeat (CPB) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'(req_busy), 32'd0);
        chk("rst_mid_tx",   32'(tx),       32'd1);
        chk("rst_mid_done", 32'(req_done), 32'd0);
        rst  = 1'b0;
        hits = 0;
        for (int i = 0; i < 12*CPB; i++) begin
            @(posedge clk);
            #1;
            if (req_done !== 1'b0 || req_busy !== 1'b0 || tx !== 1'b1) hits++;
        end
        chk("rst_mid_quiet", 32'(hits), 32'd0);
        run_frame("post_rst_knock", HUSKY_KNOCK, 8'd0, '0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < MD; k++) d[8*k +: 8] = 8'($urandom);
            run_frame($sformatf("rnd%0d", r), 8'($urandom), 8'($urandom_range(0, MD)), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
